// File: rtl/spi_xfer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_seq_pkg
// Description : Shared spi_core register map, ctrl bit positions and the
//               transfer sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_xfer_seq_pkg;

    localparam logic [7:0] c_ADDR_TXRX = 8'h00;
    localparam logic [7:0] c_ADDR_CTRL = 8'h10;
    localparam logic [7:0] c_ADDR_DIV  = 8'h14;
    localparam logic [7:0] c_ADDR_SS   = 8'h18;

    localparam int c_CTRL_W          = 14;
    localparam int c_CTRL_RX_SEL_BIT = 7;
    localparam int c_CTRL_GO_BIT     = 8;
    localparam int c_CTRL_IE_BIT     = 12;
    localparam int c_CTRL_TX_SEL_BIT = 13;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_DIV  = 4'd1,
        ST_W_SS   = 4'd2,
        ST_W_CTRL = 4'd3,
        ST_W_TX   = 4'd4,
        ST_W_GO   = 4'd5,
        ST_WAIT   = 4'd6,
        ST_R_RX   = 4'd7,
        ST_R_CAP  = 4'd8,
        ST_RSP    = 4'd9
    } state_e;

    // The sequencer owns GO, IE and the TX/RX selects; everything else passes through.
    function automatic logic [c_CTRL_W-1:0] ctrl_word(input logic [c_CTRL_W-1:0] cfg,
                                                      input logic                go);
        logic [c_CTRL_W-1:0] w_ctrl;
        w_ctrl                    = cfg;
        w_ctrl[c_CTRL_IE_BIT]     = 1'b1;
        w_ctrl[c_CTRL_TX_SEL_BIT] = 1'b1;
        w_ctrl[c_CTRL_RX_SEL_BIT] = 1'b1;
        w_ctrl[c_CTRL_GO_BIT]     = go;
        return w_ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_fifo
// Description : Power-of-two deep command FIFO with synchronous reset and
//               first-word-fall-through head output.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = (r_count == (c_PTR_W + 1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_seq
// Description : Queues TX characters and runs each as a full spi_core register
//               sequence (divider, SS, ctrl, TX, GO, wait, RX read), returning
//               the RX character or a timeout abort as a response.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_seq
    import spi_xfer_seq_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_data_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_data_o,
    output logic                rsp_err_o,
    input  logic [15:0]         cfg_divider_i,
    input  logic [7:0]          cfg_ss_i,
    input  logic [c_CTRL_W-1:0] cfg_ctrl_i,
    output logic [7:0]          addr_o,
    output logic [31:0]         wdata_o,
    output logic [3:0]          be_o,
    output logic                we_o,
    output logic                re_o,
    input  logic [31:0]         rdata_i,
    input  logic                intr_rx_i,
    input  logic                intr_tx_i,
    output logic                busy_o
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic [7:0]            r_ss;
    logic [c_CTRL_W-1:0]   r_ctrl;
    logic [31:0]           r_rsp_data;
    logic                  r_rsp_err;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [31:0]           w_head;
    logic                  w_we;
    logic                  w_re;
    logic                  w_intr;
    logic                  w_timeout;

    assign w_push      = cmd_valid_i & cmd_ready_o;
    assign w_pop       = (r_state == ST_W_TX);
    assign w_intr      = intr_rx_i | intr_tx_i;
    assign w_timeout   = ~w_intr & (r_wait_cnt == c_CNT_LAST);

    assign cmd_ready_o = ~w_full;
    assign rsp_valid_o = (r_state == ST_RSP);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign be_o        = 4'hF;
    assign busy_o      = (r_state != ST_IDLE) | ~w_empty;
    // Strobes are killed while reset is held so a mid-sequence reset never touches spi_core.
    assign we_o        = w_we & ~rst_i;
    assign re_o        = w_re & ~rst_i;

    spi_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (cmd_data_i),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        addr_o      = 8'h00;
        wdata_o     = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !rsp_valid_o) w_state_nxt = ST_W_DIV;
            end
            ST_W_DIV: begin
                w_we        = 1'b1;
                addr_o      = c_ADDR_DIV;
                wdata_o     = {16'h0, cfg_divider_i};
                w_state_nxt = ST_W_SS;
            end
            ST_W_SS: begin
                w_we        = 1'b1;
                addr_o      = c_ADDR_SS;
                wdata_o     = {24'h0, r_ss};
                w_state_nxt = ST_W_CTRL;
            end
            ST_W_CTRL: begin
                w_we        = 1'b1;
                addr_o      = c_ADDR_CTRL;
                wdata_o     = {18'h0, ctrl_word(r_ctrl, 1'b0)};
                w_state_nxt = ST_W_TX;
            end
            ST_W_TX: begin
                w_we        = 1'b1;
                addr_o      = c_ADDR_TXRX;
                wdata_o     = w_head;
                w_state_nxt = ST_W_GO;
            end
            ST_W_GO: begin
                w_we        = 1'b1;
                addr_o      = c_ADDR_CTRL;
                wdata_o     = {18'h0, ctrl_word(r_ctrl, 1'b1)};
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_intr)         w_state_nxt = ST_R_RX;
                else if (w_timeout) w_state_nxt = ST_RSP;
            end
            ST_R_RX: begin
                w_re        = 1'b1;
                addr_o      = c_ADDR_TXRX;
                w_state_nxt = ST_R_CAP;
            end
            ST_R_CAP: begin
                w_state_nxt = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
            r_ss       <= '0;
            r_ctrl     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_W_DIV: begin
                    r_ss   <= cfg_ss_i;
                    r_ctrl <= cfg_ctrl_i;
                end
                ST_W_GO: begin
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                ST_R_CAP: begin
                    r_rsp_data <= rdata_i;
                    r_rsp_err  <= 1'b0;
                end
                default: begin
                    r_wait_cnt <= r_wait_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, maximum WAIT cycles before abort.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_data_i  in  32  TX character.
- rsp_valid_o  out  1  response held.
- rsp_ready_i  in  1  response consumer ready.
- rsp_data_o  out  32  RX character.
- rsp_err_o  out  1  response is a timeout abort.
- cfg_divider_i  in  16  SCLK divider value.
- cfg_ss_i  in  8  slave-select mask.
- cfg_ctrl_i  in  14  ctrl word; GO forced 0, IE forced 1, TX_SEL/RX_SEL forced 1 by block.
- addr_o  out  8  spi_core register byte address.
- wdata_o  out  32  spi_core write data.
- be_o  out  4  byte enables; always 4'hF.
- we_o  out  1  register write strobe.
- re_o  out  1  register read strobe.
- rdata_i  in  32  spi_core read data, valid one cycle after re_o.
- intr_rx_i, intr_tx_i  in  1 each  spi_core completion pulses.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-004 Command accepted on cycle where cmd_valid_i & cmd_ready_o; pushed into CMD_DEPTH FIFO.
REQ-005 Push while full SHALL be impossible (cmd_ready_o low); simultaneous push and pop when full SHALL be refused (ready reflects registered count only).
REQ-006 FSM states: IDLE, W_DIV, W_SS, W_CTRL, W_TX, W_GO, WAIT, R_RX, R_CAP, RSP.
REQ-007 IDLE -> W_DIV when FIFO non-empty and rsp_valid_o low; FIFO head popped on entry to W_TX.
REQ-008 Each W_* state SHALL assert we_o exactly one cycle: W_DIV addr 0x14 data cfg_divider_i; W_SS addr 0x18 data cfg_ss_i; W_CTRL addr 0x10 data ctrl (GO=0); W_TX addr 0x00 data FIFO head; W_GO addr 0x10 data ctrl with GO (bit 8) = 1.
REQ-009 cfg_* sampled in W_DIV and held in registers for the whole command.
REQ-010 WAIT: exit to R_RX on intr_rx_i | intr_tx_i; a pulse arriving in any other state SHALL be ignored.
REQ-011 WAIT counter SHALL clear on entry; on reaching TIMEOUT_CYC, go to RSP with rsp_err_o=1, rsp_data_o=0.
REQ-012 R_RX asserts re_o with addr 0x00 for one cycle; R_CAP captures rdata_i into rsp_data_o, rsp_err_o=0.
REQ-013 RSP asserts rsp_valid_o, holds data stable until rsp_ready_i; transfer cycle -> IDLE.
REQ-014 we_o and re_o SHALL never be high together; both low outside W_*/R_RX.
REQ-015 Minimum latency cmd accept -> rsp_valid_o: 8 cycles plus WAIT duration.
REQ-016 cmd_ready_o SHALL remain asserted during transfers while FIFO not full (pipelined acceptance).

Reset
REQ-017 rst_i high SHALL, next edge, force IDLE, FIFO empty, counter 0, and outputs: cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, we_o=0, re_o=0, addr_o=0, wdata_o=0, busy_o=0.
REQ-018 Reset mid-transfer SHALL discard in-flight and queued commands; no bus strobe in the reset cycle.

Structure
REQ-019 Register offsets (0x00, 0x10, 0x14, 0x18), GO/IE/TX_SEL/RX_SEL bit positions, and the FSM state encoding SHALL live in the shared SPI defines package.
REQ-020 Command FIFO SHALL be one sub-module, spi_cmd_fifo (push/pop/full/empty, synchronous reset).

Verification
REQ-021 Single command 0xA5 with loopback slave returning 0x3C -> bus writes in order 0x14,0x18,0x10,0x00,0x10(GO); one read of 0x00; rsp_data_o=0x3C, rsp_err_o=0.
REQ-022 Push 5 commands back-to-back with rsp_ready_i=0, CMD_DEPTH=4 -> cmd_ready_o drops after 4 accepted (5th waits); all 5 responses delivered in order once rsp_ready_i=1.
REQ-023 No interrupt, TIMEOUT_CYC=16 -> rsp_valid_o with rsp_err_o=1, rsp_data_o=0 after 16 WAIT cycles; next command proceeds normally.
REQ-024 Spurious intr_tx_i during W_SS -> ignored; FSM still waits in WAIT for the real pulse.
REQ-025 rst_i asserted in WAIT with 2 queued commands -> next cycle IDLE, busy_o=0, no further strobes, no responses.
REQ-026 rsp_ready_i held low 10 cycles in RSP -> rsp_data_o stable, no new bus activity until handshake.
